// File: rtl/ntt_seq.sv
// ntt_seq: sequential N-point number-theoretic transform, X[k] = sum_j x[j]*w^(j*k) mod q.
// Samples are loaded into a buffer, and one modular MAC walks the N*N terms row by row.
// Results then stream out in natural order. q and w are captured with the first sample.
module ntt_seq #(
  parameter int N    = 16,
  parameter int W    = 8,
  parameter int LOGN = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  input  logic [W-1:0]    q,
  input  logic [W-1:0]    w,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic [LOGN-1:0] out_idx,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_COMPUTE,
    S_OUTPUT
  } state_e;

  localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

  // Reduce a double-width value mod m. A modulus below 2 yields 0 so every result is defined.
  function automatic logic [W-1:0] mod_reduce(input logic [2*W-1:0] a, input logic [W-1:0] m);
    logic [2*W-1:0] r;
    if (m < W'(2)) r = '0;
    else           r = a % {{W{1'b0}}, m};
    return r[W-1:0];
  endfunction

  // Add two residues of m: the W+1 bit sum needs at most one subtraction.
  function automatic logic [W-1:0] add_mod(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] m);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (m < W'(2))           s = '0;
    else if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[W-1:0];
  endfunction

  state_e          state_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [W-1:0]    out_data_q;
  logic            busy_q;
  logic [LOGN-1:0] cnt_q;
  logic [LOGN-1:0] k_q;
  logic [LOGN-1:0] j_q;
  logic [W-1:0]    acc_q;
  logic [W-1:0]    pw_q;
  logic [W-1:0]    wk_q;
  logic [W-1:0]    modulus_q;
  logic [W-1:0]    root_q;

  logic [W-1:0]    x_mem   [N];
  logic [W-1:0]    res_mem [N];

  logic            in_fire;
  logic [LOGN-1:0] k_next;
  logic [2*W-1:0]  prod_x;
  logic [W-1:0]    term;
  logic [W-1:0]    acc_d;
  logic [W-1:0]    pw_d;
  logic [W-1:0]    wk_d;
  logic [W-1:0]    one_mod;

  assign in_fire   = in_valid && in_ready_q;
  assign k_next    = k_q + LOGN'(1);

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = k_q;
  assign busy      = busy_q;

  // One MAC step: x[0] (w^0 = 1) seeds each row, later columns add x[j]*w^(jk).
  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    prod_x  = '0;
    term    = '0;
    acc_d   = acc_q;
    pw_d    = pw_q;
    wk_d    = wk_q;
    one_mod = mod_reduce({{(2*W-1){1'b0}}, 1'b1}, modulus_q);
    prod_x  = {{W{1'b0}}, x_mem[j_q]} * {{W{1'b0}}, pw_q};
    term    = mod_reduce(prod_x, modulus_q);
    if (j_q == '0) begin
      acc_d = mod_reduce({{W{1'b0}}, x_mem[0]}, modulus_q);
      pw_d  = wk_q;
    end else begin
      acc_d = add_mod(acc_q, term, modulus_q);
      pw_d  = mod_reduce({{W{1'b0}}, pw_q} * {{W{1'b0}}, wk_q}, modulus_q);
    end
    wk_d = mod_reduce({{W{1'b0}}, wk_q} * {{W{1'b0}}, root_q}, modulus_q);
  end

  // Sample buffer and result buffer writes.
  always_ff @(posedge clk) begin
    // NOTE: the buffers carry no reset; control state guarantees stale contents are never output.
    if (in_fire && state_q == S_LOAD)
      x_mem[cnt_q] <= in_data;
    if (state_q == S_COMPUTE && j_q == LAST)
      res_mem[k_q] <= acc_d;
  end

  // Control FSM with registered handshake outputs and the MAC datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q     <= S_LOAD;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      k_q         <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      pw_q        <= '0;
      wk_q        <= '0;
      modulus_q   <= '0;
      root_q      <= '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (in_fire) begin
            if (cnt_q == '0) begin
              modulus_q <= q;
              root_q    <= w;
            end
            if (cnt_q == LAST) begin
              cnt_q      <= '0;
              k_q        <= '0;
              j_q        <= '0;
              wk_q       <= one_mod;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
              state_q    <= S_COMPUTE;
            end else begin
              cnt_q <= cnt_q + LOGN'(1);
            end
          end
        end
        S_COMPUTE: begin
          acc_q <= acc_d;
          pw_q  <= pw_d;
          if (j_q == LAST) begin
            j_q  <= '0;
            wk_q <= wk_d;
            if (k_q == LAST) begin
              k_q         <= '0;
              out_valid_q <= 1'b1;
              out_data_q  <= res_mem[0];
              state_q     <= S_OUTPUT;
            end else begin
              k_q <= k_next;
            end
          end else begin
            j_q <= j_q + LOGN'(1);
          end
        end
        S_OUTPUT: begin
          if (out_ready) begin
            if (k_q == LAST) begin
              k_q         <= '0;
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= S_LOAD;
            end else begin
              k_q        <= k_next;
              out_data_q <= res_mem[k_next];
            end
          end
        end
        default: begin
          state_q     <= S_LOAD;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_seq.sv
// tb_ntt_seq: randomized and directed frames for ntt_seq, checked by a scoreboard fed from a
// direct-summation NTT model; a separate monitor pops expectations on each output handshake.
module tb_ntt_seq;

  localparam int N    = 16;
  localparam int W    = 8;
  localparam int LOGN = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic [W-1:0]    q;
  logic [W-1:0]    w;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [LOGN-1:0] out_idx;
  logic            busy;

  ntt_seq #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .q        (q),
    .w        (w),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit rand_ready    = 1'b0;
  bit first_pending = 1'b0;
  int exp_first     = 0;
  bit last_pending  = 1'b0;
  bit prev_stall    = 1'b0;
  int prev_data     = 0;
  int prev_idx      = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: direct summation of the transform definition.
  function automatic longint pow_mod(input longint b, input int e, input longint m);
    longint r;
    r = 1 % m;
    for (int i = 0; i < e; i++) r = (r * b) % m;
    return r;
  endfunction

  function automatic int ref_x(input int xs[N], input int qq, input int ww, input int k);
    longint acc;
    acc = 0;
    if (qq < 2) return 0;
    for (int j = 0; j < N; j++)
      acc = (acc + longint'(xs[j]) * pow_mod(ww, j * k, qq)) % qq;
    return int'(acc);
  endfunction

  // Monitor: compares each output handshake against the scoreboard and checks stall stability.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall   = 1'b0;
      last_pending = 1'b0;
    end else begin
      if (last_pending) begin
        check("ready_after_frame", int'(in_ready), 1);
        check("valid_after_frame", int'(out_valid), 0);
        last_pending = 1'b0;
      end
      if (prev_stall) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_data", int'(out_data), prev_data);
        check("stall_idx", int'(out_idx), prev_idx);
      end
      if (out_valid && first_pending) begin
        check("first_out_latency", cyc, exp_first);
        first_pending = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got idx %0d data %0d, expected no output",
                   out_idx, out_data);
        end else begin
          mon_e = sb.pop_front();
          check("out_idx", int'(out_idx), mon_e.idx);
          check("out_data", int'(out_data), mon_e.data);
          if (mon_e.idx == N - 1) last_pending = 1'b1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = int'(out_data);
      prev_idx   = int'(out_idx);
    end
  end

  // Downstream ready: always high or randomly toggled.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_idx", int'(out_idx), 0);
    rst = 1'b0;
    sb.delete();
    first_pending = 1'b0;
  endtask

  task automatic send_frame(input int xs[N], input int qq, input int ww);
    int t_last;
    int n;
    exp_t e;
    t_last = 0;
    for (int j = 0; j < N; j++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = W'(xs[j]);
      q        = (j == 0) ? W'(qq) : W'($urandom);
      w        = (j == 0) ? W'(ww) : W'($urandom);
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
        n++;
        @(negedge clk);
      end
      if (!in_ready) check("in_ready_timeout", 0, 1);
      t_last = cyc;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_data  = W'($urandom);
    for (int k = 0; k < N; k++) begin
      e.idx  = k;
      e.data = ref_x(xs, qq, ww, k);
      sb.push_back(e);
    end
    exp_first     = t_last + N * N + 1;
    first_pending = 1'b1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("drain_timeout", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int xs[N];
    int qq;
    int ww;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    q        = '0;
    w        = '0;
    apply_reset();

    // Impulse at x[0]: every X[k] = 1.
    xs = '{default: 0};
    xs[0] = 1;
    send_frame(xs, 17, 3);
    wait_drain();

    // All ones: X[0] = 16, rest 0.
    xs = '{default: 1};
    send_frame(xs, 17, 3);
    wait_drain();

    // Impulse at x[1]: X[k] = 3^k mod 17.
    xs = '{default: 0};
    xs[1] = 1;
    send_frame(xs, 17, 3);
    wait_drain();

    // Same frame under random backpressure.
    rand_ready = 1'b1;
    send_frame(xs, 17, 3);
    wait_drain();
    rand_ready = 1'b0;

    // Abort mid-COMPUTE, then a fresh frame.
    xs = '{default: 5};
    send_frame(xs, 17, 3);
    repeat (40) @(posedge clk);
    #1;
    check("compute_busy", int'(busy), 1);
    check("compute_in_ready", int'(in_ready), 0);
    check("compute_out_valid", int'(out_valid), 0);
    apply_reset();
    xs = '{default: 1};
    send_frame(xs, 17, 3);
    wait_drain();

    // Degenerate moduli: all results forced to 0.
    for (int m = 0; m < 2; m++) begin
      foreach (xs[i]) xs[i] = int'($urandom_range(0, 255));
      send_frame(xs, m, int'($urandom_range(0, 255)));
      wait_drain();
    end

    // Random moduli, roots, samples and backpressure.
    for (int f = 0; f < 6; f++) begin
      foreach (xs[i]) xs[i] = int'($urandom_range(0, 255));
      qq = int'($urandom_range(2, 255));
      ww = int'($urandom_range(0, 255));
      rand_ready = 1'($urandom_range(0, 1));
      send_frame(xs, qq, ww);
      wait_drain();
    end
    rand_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
